// File: rtl/mux4_rr_arbiter_if.sv
// Bundle for the four request/data sources, the grant strobe and the registered
// y/y_valid/y_ready output channel of the round-robin mux arbiter.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 6
);
    logic [3:0]       req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] z;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic [1:0]       sel;
    logic             busy;

    modport master (
        output req, a, x, k, z, y_ready,
        input  gnt, y, y_valid, sel, busy
    );

    modport slave (
        input  req, a, x, k, z, y_ready,
        output gnt, y, y_valid, sel, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded burst ownership feeding a single registered
// valid/ready output stage for the four-way mux datapath.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 6,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst,
    mux4_rr_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE,
        OWN
    } arbState_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    arbState_t        r_state;
    arbState_t        w_stateNext;
    logic [1:0]       r_owner;
    logic [1:0]       w_ownerNext;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptrNext;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cntNext;
    logic [WIDTH-1:0] r_y;
    logic [1:0]       r_sel;
    logic             r_yValid;

    logic             w_take;
    logic             w_keep;
    logic             w_ownerOnly;
    logic [3:0]       w_ownerBit;
    logic [1:0]       w_winner;
    logic [WIDTH-1:0] w_data;

    // First requesting index strictly after 'last', wrapping back to 'last' itself.
    function automatic logic [1:0] rrPick(input logic [3:0] reqs, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int i = 3; i >= 0; i--) begin
            idx = last + 2'(i) + 2'd1;
            if (reqs[idx]) pick = idx;
        end
        return pick;
    endfunction

    always_comb begin
        w_take      = (|bus.req) & (~r_yValid | bus.y_ready) & ~rst;
        w_ownerBit  = 4'b0001 << r_owner;
        w_ownerOnly = (bus.req == w_ownerBit);
        w_keep      = (r_state == OWN) && bus.req[r_owner] &&
                      ((r_cnt < MAX_CNT) || w_ownerOnly);

        if (r_state == IDLE) begin
            w_winner = rrPick(bus.req, r_ptr);
        end else if (w_keep) begin
            w_winner = r_owner;
        end else begin
            // An owner that used up its burst is skipped whenever anyone else waits.
            w_winner = rrPick(bus.req & ~w_ownerBit, r_owner);
        end

        case (w_winner)
            2'd0:    w_data = bus.a;
            2'd1:    w_data = bus.x;
            2'd2:    w_data = bus.k;
            default: w_data = bus.z;
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        w_ownerNext = r_owner;
        w_ptrNext   = r_ptr;
        w_cntNext   = r_cnt;

        if (w_take) begin
            w_stateNext = OWN;
            w_ownerNext = w_winner;
            w_ptrNext   = w_winner;
            if (w_keep) begin
                w_cntNext = (r_cnt >= MAX_CNT) ? 4'd1 : r_cnt + 4'd1;
            end else begin
                w_cntNext = 4'd1;
            end
        end else if ((bus.req == 4'd0) && (r_state == OWN)) begin
            w_stateNext = IDLE;
            w_ptrNext   = r_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= 2'd0;
            r_ptr    <= 2'd3;
            r_cnt    <= 4'd0;
            r_y      <= '0;
            r_sel    <= 2'd0;
            r_yValid <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_owner <= w_ownerNext;
            r_ptr   <= w_ptrNext;
            r_cnt   <= w_cntNext;
            if (w_take) begin
                r_y      <= w_data;
                r_sel    <= w_winner;
                r_yValid <= 1'b1;
            end else if (r_yValid && bus.y_ready) begin
                r_yValid <= 1'b0;
            end
        end
    end

    assign bus.gnt     = w_take ? (4'b0001 << w_winner) : 4'b0000;
    assign bus.y       = r_y;
    assign bus.sel     = r_sel;
    assign bus.y_valid = r_yValid;
    assign bus.busy    = (r_state == OWN);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Table-driven bench for mux4_rr_arbiter: hand-derived per-cycle grants, with a
// scoreboard queue carrying each granted beat to the registered output check.
module tb_mux4_rr_arbiter;
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [5:0] a;
        logic [5:0] x;
        logic [5:0] k;
        logic [5:0] z;
        logic       rdy;
        logic [3:0] expGnt;
        logic       expBusy;
    } vec_t;

    typedef struct {
        logic [5:0] y;
        logic [1:0] sel;
    } beat_t;

    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    beat_t      sbQueue[$];
    logic [5:0] expY;
    logic [1:0] expSel;
    logic       expValid;
    vec_t       vecs[$];

    mux4_rr_arbiter_if #(.WIDTH(6)) busIf ();

    mux4_rr_arbiter #(
        .WIDTH(6),
        .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(logic r, logic [3:0] q, logic rdy, logic [3:0] g,
                                 logic b, logic [5:0] av = 6'd1, logic [5:0] zv = 6'd4);
        vec_t v;
        v.rst     = r;
        v.req     = q;
        v.a       = av;
        v.x       = 6'd2;
        v.k       = 6'd3;
        v.z       = zv;
        v.rdy     = rdy;
        v.expGnt  = g;
        v.expBusy = b;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [7:0] act, logic [7:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle, check the combinational grant, then the registered outputs.
    task automatic applyStimulus(vec_t v);
        beat_t b;
        @(negedge clk);
        rst            = v.rst;
        busIf.req      = v.req;
        busIf.a        = v.a;
        busIf.x        = v.x;
        busIf.k        = v.k;
        busIf.z        = v.z;
        busIf.y_ready  = v.rdy;
        #1;
        checkOutput("gnt", {4'd0, busIf.gnt}, {4'd0, v.expGnt});
        if (v.expGnt != 4'd0) begin
            case (v.expGnt)
                4'b0001: begin b.y = v.a; b.sel = 2'd0; end
                4'b0010: begin b.y = v.x; b.sel = 2'd1; end
                4'b0100: begin b.y = v.k; b.sel = 2'd2; end
                default: begin b.y = v.z; b.sel = 2'd3; end
            endcase
            sbQueue.push_back(b);
        end
        @(posedge clk);
        #1;
        if (v.rst) begin
            sbQueue.delete();
            expY     = 6'd0;
            expSel   = 2'd0;
            expValid = 1'b0;
        end else if (sbQueue.size() > 0) begin
            b        = sbQueue.pop_front();
            expY     = b.y;
            expSel   = b.sel;
            expValid = 1'b1;
        end else if (expValid && v.rdy) begin
            expValid = 1'b0;
        end
        checkOutput("y", {2'd0, busIf.y}, {2'd0, expY});
        checkOutput("sel", {6'd0, busIf.sel}, {6'd0, expSel});
        checkOutput("y_valid", {7'd0, busIf.y_valid}, {7'd0, expValid});
        checkOutput("busy", {7'd0, busIf.busy}, {7'd0, v.expBusy});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        passCount  = 0;
        expY       = 6'd0;
        expSel     = 2'd0;
        expValid   = 1'b0;
        rst        = 1'b1;
        busIf.req  = 4'd0;
        busIf.a    = 6'd0;
        busIf.x    = 6'd0;
        busIf.k    = 6'd0;
        busIf.z    = 6'd0;
        busIf.y_ready = 1'b1;

        // Reset, then a lone requester that must never be forced off.
        vecs.push_back(mkv(1, 4'b0000, 1, 4'b0000, 0));
        vecs.push_back(mkv(1, 4'b0000, 1, 4'b0000, 0));
        for (int i = 0; i < 6; i++) vecs.push_back(mkv(0, 4'b0001, 1, 4'b0001, 1, 6'd21));
        vecs.push_back(mkv(0, 4'b0000, 1, 4'b0000, 0, 6'd21));

        // Reset restores source 0 priority, then four-way round-robin in bursts of four.
        vecs.push_back(mkv(1, 4'b1111, 1, 4'b0000, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 4'b1111, 1, 4'b0001, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 4'b1111, 1, 4'b0010, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 4'b1111, 1, 4'b0100, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 4'b1111, 1, 4'b1000, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 4'b1111, 1, 4'b0001, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 4'b1111, 1, 4'b0010, 1));
        for (int i = 0; i < 2; i++) vecs.push_back(mkv(0, 4'b1111, 1, 4'b0100, 1));

        // Reset mid-burst while y holds a k beat; first grant afterwards is source 0.
        vecs.push_back(mkv(1, 4'b1111, 1, 4'b0000, 0));
        vecs.push_back(mkv(0, 4'b1111, 1, 4'b0001, 1));

        // Backpressure: one grant, five stalled cycles, then resume.
        vecs.push_back(mkv(0, 4'b0000, 1, 4'b0000, 0));
        vecs.push_back(mkv(0, 4'b0011, 0, 4'b0010, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mkv(0, 4'b0011, 0, 4'b0000, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mkv(0, 4'b0011, 1, 4'b0010, 1));
        for (int i = 0; i < 2; i++) vecs.push_back(mkv(0, 4'b0011, 1, 4'b0001, 1));

        // Early drop: x owns with cnt=2, then hands straight to k.
        vecs.push_back(mkv(0, 4'b0000, 1, 4'b0000, 0));
        vecs.push_back(mkv(0, 4'b0010, 1, 4'b0010, 1));
        vecs.push_back(mkv(0, 4'b0010, 1, 4'b0010, 1));
        vecs.push_back(mkv(0, 4'b0100, 1, 4'b0100, 1));
        vecs.push_back(mkv(0, 4'b0000, 1, 4'b0000, 0));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Drain and refill in the same cycle keeps y_valid high with z's new beat.
        applyStimulus(mkv(0, 4'b1000, 0, 4'b1000, 1, 6'd1, 6'd4));
        applyStimulus(mkv(0, 4'b1000, 1, 4'b1000, 1, 6'd1, 6'd9));
        applyStimulus(mkv(0, 4'b0000, 1, 4'b0000, 0, 6'd1, 6'd9));
        applyStimulus(mkv(0, 4'b0000, 1, 4'b0000, 0, 6'd1, 6'd9));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
